// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_GRF = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10,
    FWD_E   = 2'b11
  } fwd_sel_e;

  // All-ones marks an unused operand; users slice it down to their Tuse width.
  localparam logic [31:0] TUSE_NONE = '1;

  function automatic logic [31:0] sat_dec(input logic [31:0] x);
    return (x == '0) ? '0 : x - 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage hazard request and stall/forward response bundle for hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TNEW_W = 2
);
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic [REG_AW-1:0] d_a3;
  logic              d_we;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_use;
  logic              d_md_start;
  logic              d_md_div;
  logic              stall;
  logic              md_busy;
  logic [1:0]        d_fwd_rs;
  logic [1:0]        d_fwd_rt;
  logic [1:0]        e_fwd_rs;
  logic [1:0]        e_fwd_rt;
  logic              m_fwd_rt;
  logic [31:0]       stall_count;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_we, d_tnew,
           d_md_use, d_md_start, d_md_div,
    input  stall, md_busy, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt,
           m_fwd_rt, stall_count
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_we, d_tnew,
           d_md_use, d_md_start, d_md_div,
    output stall, md_busy, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt,
           m_fwd_rt, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Busy counter for the multi-cycle mult/div unit; busy while the count is nonzero.
module md_busy_ctr #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for the F/D/E/M/W pipeline with E/M/W shadow copies.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TNEW_W      = 2,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);
  localparam logic [TNEW_W-1:0] TUSE_NONE_W = TUSE_NONE[TNEW_W-1:0];

  logic [REG_AW-1:0] e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
  logic              e_we, m_we, w_we;
  logic [TNEW_W-1:0] e_tnew, m_tnew;
  logic              stall;
  logic              md_busy;

  function automatic logic hits(input logic [REG_AW-1:0] s,
                                input logic [REG_AW-1:0] a3,
                                input logic              we);
    return (s != '0) && we && (a3 == s);
  endfunction

  function automatic logic src_stall(input logic [REG_AW-1:0] s,
                                     input logic [TNEW_W-1:0] tuse);
    return (tuse != TUSE_NONE_W) &&
           ((hits(s, e_a3, e_we) && (e_tnew > tuse)) ||
            (hits(s, m_a3, m_we) && (m_tnew > tuse)));
  endfunction

  // W carries no Tnew: every result is available by the time it reaches W.
  function automatic fwd_sel_e d_sel(input logic [REG_AW-1:0] s);
    if (hits(s, e_a3, e_we) && (e_tnew == '0))      return FWD_E;
    else if (hits(s, m_a3, m_we) && (m_tnew == '0)) return FWD_M;
    else if (hits(s, w_a3, w_we))                   return FWD_W;
    else                                            return FWD_GRF;
  endfunction

  function automatic fwd_sel_e e_sel(input logic [REG_AW-1:0] s);
    if (hits(s, m_a3, m_we) && (m_tnew == '0)) return FWD_M;
    else if (hits(s, w_a3, w_we))              return FWD_W;
    else                                       return FWD_GRF;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs   <= '0;
      e_rt   <= '0;
      e_a3   <= '0;
      e_we   <= 1'b0;
      e_tnew <= '0;
      m_rt   <= '0;
      m_a3   <= '0;
      m_we   <= 1'b0;
      m_tnew <= '0;
      w_a3   <= '0;
      w_we   <= 1'b0;
    end else begin
      if (stall) begin
        e_rs   <= '0;
        e_rt   <= '0;
        e_a3   <= '0;
        e_we   <= 1'b0;
        e_tnew <= '0;
      end else begin
        e_rs   <= hz.d_rs;
        e_rt   <= hz.d_rt;
        e_a3   <= hz.d_a3;
        e_we   <= hz.d_we;
        e_tnew <= hz.d_tnew;
      end
      m_rt   <= e_rt;
      m_a3   <= e_a3;
      m_we   <= e_we;
      m_tnew <= TNEW_W'(sat_dec(32'(e_tnew)));
      w_a3   <= m_a3;
      w_we   <= m_we;
    end
  end

  always_comb begin
    stall = 1'b0;
    stall = src_stall(hz.d_rs, hz.d_tuse_rs) ||
            src_stall(hz.d_rt, hz.d_tuse_rt) ||
            (hz.d_md_use && md_busy);
  end

  always_comb begin
    hz.d_fwd_rs = FWD_GRF;
    hz.d_fwd_rt = FWD_GRF;
    hz.e_fwd_rs = FWD_GRF;
    hz.e_fwd_rt = FWD_GRF;
    hz.m_fwd_rt = 1'b0;
    hz.d_fwd_rs = d_sel(hz.d_rs);
    hz.d_fwd_rt = d_sel(hz.d_rt);
    hz.e_fwd_rs = e_sel(e_rs);
    hz.e_fwd_rt = e_sel(e_rt);
    hz.m_fwd_rt = hits(m_rt, w_a3, w_we);
  end

  // A start is only honoured when the instruction actually leaves D.
  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_ctr (
    .clk   (clk),
    .reset (reset),
    .start (hz.d_md_start && !stall),
    .div   (hz.d_md_div),
    .busy  (md_busy)
  );

  assign hz.stall   = stall;
  assign hz.md_busy = md_busy;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_count = stall_cnt;
`else
  assign hz.stall_count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random traffic vs a timing model.
module tb_hazard_ctrl;
  logic clk;
  logic reset;

  hazard_ctrl_if #(.REG_AW(5), .TNEW_W(2)) hz ();

  hazard_ctrl #(
    .REG_AW      (5),
    .TNEW_W      (2),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: each in-flight instruction is tracked by the absolute
  // cycle at which its result exists; slot 0 = E, 1 = M, 2 = W.
  typedef struct {
    logic [4:0] rs, rt, a3;
    bit         we;
    int         ready;
  } ent_t;

  ent_t        q[3];
  int          cyc;
  int          md_free_at;
  int unsigned model_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) q[i] = '{rs: 0, rt: 0, a3: 0, we: 0, ready: 0};
    md_free_at = cyc;
    model_cnt  = 0;
  endfunction

  function automatic bit hit(int i, logic [4:0] s);
    return (s != 0) && q[i].we && (q[i].a3 == s);
  endfunction

  function automatic int rem(int i);
    if (i == 2) return 0;
    return (q[i].ready > cyc) ? q[i].ready - cyc : 0;
  endfunction

  function automatic bit src_stall(logic [4:0] s, logic [1:0] tuse);
    if (tuse == 2'd3) return 0;
    for (int i = 0; i < 2; i++) if (hit(i, s) && rem(i) > int'(tuse)) return 1;
    return 0;
  endfunction

  function automatic int sel_from(int first, logic [4:0] s);
    for (int i = first; i < 3; i++) if (hit(i, s) && rem(i) == 0) return 3 - i;
    return 0;
  endfunction

  task automatic drive(input logic [4:0] rs, rt, input logic [1:0] tr, tt,
                       input logic [4:0] a3, input bit we, input logic [1:0] tn,
                       input bit mu, ms, md);
    hz.d_rs = rs; hz.d_rt = rt; hz.d_tuse_rs = tr; hz.d_tuse_rt = tt;
    hz.d_a3 = a3; hz.d_we = we; hz.d_tnew = tn;
    hz.d_md_use = mu; hz.d_md_start = ms; hz.d_md_div = md;
  endtask

  task automatic step(output bit st);
    bit busy;
    @(negedge clk);
    busy = (cyc < md_free_at);
    st = src_stall(hz.d_rs, hz.d_tuse_rs) || src_stall(hz.d_rt, hz.d_tuse_rt) ||
         (hz.d_md_use && busy);
    check("stall",       hz.stall,    st);
    check("md_busy",     hz.md_busy,  busy);
    check("d_fwd_rs",    hz.d_fwd_rs, sel_from(0, hz.d_rs));
    check("d_fwd_rt",    hz.d_fwd_rt, sel_from(0, hz.d_rt));
    check("e_fwd_rs",    hz.e_fwd_rs, sel_from(1, q[0].rs));
    check("e_fwd_rt",    hz.e_fwd_rt, sel_from(1, q[0].rt));
    check("m_fwd_rt",    hz.m_fwd_rt, hit(2, q[1].rt));
    check("stall_count", hz.stall_count, CNT_EN ? model_cnt : 0);
    @(posedge clk);
    if (hz.d_md_start && !st) md_free_at = cyc + 1 + (hz.d_md_div ? 10 : 5);
    if (st) model_cnt++;
    q[2] = q[1];
    q[1] = q[0];
    if (st) q[0] = '{rs: 0, rt: 0, a3: 0, we: 0, ready: 0};
    else    q[0] = '{rs: hz.d_rs, rt: hz.d_rt, a3: hz.d_a3, we: hz.d_we,
                     ready: cyc + 1 + int'(hz.d_tnew)};
    cyc++;
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, rt, input logic [1:0] tr, tt,
                       input logic [4:0] a3, input bit we, input logic [1:0] tn,
                       input bit mu, ms, md, output int nst);
    bit st;
    drive(rs, rt, tr, tt, a3, we, tn, mu, ms, md);
    nst = 0;
    step(st);
    while (st && nst < 30) begin
      nst++;
      step(st);
    end
    check("issue_done", st, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},   hz.stall,    0);
    check({tag, "_busy"},    hz.md_busy,  0);
    check({tag, "_dfwd_rs"}, hz.d_fwd_rs, 0);
    check({tag, "_dfwd_rt"}, hz.d_fwd_rt, 0);
    check({tag, "_efwd_rs"}, hz.e_fwd_rs, 0);
    check({tag, "_efwd_rt"}, hz.e_fwd_rt, 0);
    check({tag, "_mfwd_rt"}, hz.m_fwd_rt, 0);
  endtask

  initial begin
    bit st;
    int n;
    cyc = 0;
    model_reset();
    reset = 1'b0;
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    #2;
    check_all_zero("rst");
    check("rst_count", hz.stall_count, 0);
    #5 reset = 1'b1;

    // mult then mflo: five stall cycles, issues on the sixth
    issue(0, 0, 3, 3, 0, 0, 0, 1, 1, 0, n);
    check("mult_stalls", n, 0);
    issue(0, 0, 3, 3, 8, 1, 1, 1, 0, 0, n);
    check("mflo_stalls", n, 5);
    check("s4_stall_count", hz.stall_count, CNT_EN ? 5 : 0);

    // lw $3 then addu using $3
    issue(0, 0, 3, 3, 3, 1, 2, 0, 0, 0, n);
    issue(3, 0, 1, 1, 4, 1, 1, 0, 0, 0, n);
    check("lw_use_stalls", n, 1);
    issue(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, n);
    // addu $5 then beq on $5
    issue(0, 0, 3, 3, 5, 1, 1, 0, 0, 0, n);
    issue(5, 0, 0, 3, 0, 0, 0, 0, 0, 0, n);
    check("beq_stalls", n, 1);
    // lui $7 then jr $7
    issue(0, 0, 3, 3, 7, 1, 0, 0, 0, 0, n);
    issue(7, 0, 0, 3, 0, 0, 0, 0, 0, 0, n);
    check("jr_stalls", n, 0);
    // $0 producer and consumer
    issue(0, 0, 3, 3, 0, 1, 2, 0, 0, 0, n);
    issue(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, n);
    check("r0_stalls", n, 0);

    st = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!st) begin
        bit mu;
        mu = ($urandom_range(0, 7) == 0);
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 2)), mu,
              mu && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
      end
      step(st);
    end

    // async reset mid-divide (count 6) while a stall is pending
    issue(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, n);
    while (hz.md_busy) issue(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, n);
    drive(0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
    step(st);
    check("div_start_stall", st, 0);
    drive(1, 2, 0, 0, 9, 1, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(st);
    check("pre_rst_busy",  hz.md_busy, 1);
    check("pre_rst_stall", hz.stall,   1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_rst_count", hz.stall_count, 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 300; k++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
      step(st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
